// File: rtl/divide_rate_arbiter.sv
// rtl/divide_rate_arbiter.sv - round-robin sharing of one rate divider between N requesters
module divide_rate_arbiter #(
    parameter int N          = 4,
    parameter int HOLD_EDGES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   code_in,
    input  logic             q_div,
    output logic [1:0]       control,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] pick;
    logic [1:0]       pick_code;
    logic             found;
    logic             q_prev;
    logic             edge_seen;
    logic             hold_reached;
    logic             win_req;
    logic [CNT_W-1:0] edge_cnt;
    int               idx;

    assign edge_seen    = q_div ^ q_prev;
    assign hold_reached = edge_seen && (edge_cnt >= CNT_W'(HOLD_EDGES - 1));
    assign win_req      = req[win_idx];

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_code = 2'b00;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N;
            if (req[idx]) begin
                found     = 1'b1;
                pick      = IDX_W'(idx);
                pick_code = code_in[2*idx +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped request ends the grant even when an edge arrives in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (|req) state_nxt = S_ARB;
            S_ARB:     state_nxt = found ? S_RUN : S_IDLE;
            S_RUN:     if (!win_req || hold_reached) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_prev   <= 1'b0;
            rr_ptr   <= '0;
            win_idx  <= '0;
            edge_cnt <= '0;
            control  <= 2'b00;
            grant    <= '0;
        end else begin
            q_prev <= q_div;
            case (state)
                S_ARB: begin
                    if (found) begin
                        win_idx  <= pick;
                        control  <= pick_code;
                        grant    <= N'(1) << pick;
                        edge_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (!win_req || hold_reached) begin
                        grant <= '0;
                    end
                    if (win_req && edge_seen && (edge_cnt != CNT_W'(HOLD_EDGES))) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    rr_ptr <= (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
